// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch sequencer. A four-state FSM (IDLE, ADDR, READ, DONE)
//   presents a byte address to instruction memory, strobes a read, latches
//   the returned 16-bit word into the instruction register and advances the
//   PC by two, wrapping at the end of the memory.
//
// Parameters
//   MEM_BYTES  instruction-memory size in bytes; legal PCs are even and
//              below this value
//   RESET_PC   PC value loaded by reset
//
// Ports
//   clk        rising-edge system clock
//   rst        asynchronous active-high reset
//   fetch_req  request the next instruction (level, honoured only in IDLE)
//   stall      holds off the start of a new fetch while high
//   pc_load    load pc_target into the PC (honoured only in IDLE)
//   pc_target  branch/jump target byte address
//   instr_in   word returned by memory: {byte[pc+1], byte[pc]}
//   pc         byte address to instruction memory (registered)
//   im_read    memory read strobe (registered)
//   ir         instruction register (registered)
//   ir_valid   one-cycle pulse marking a newly fetched word in ir
//   busy       high whenever the FSM is not in IDLE
//   fault      sticky flag set by an illegal pc_target; cleared only by reset
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int          MEM_BYTES = 32,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        stall,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    input  logic [15:0] instr_in,
    output logic [15:0] pc,
    output logic        im_read,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    // One extra bit so the limit and the pc+2 sum can be compared without
    // overflow when MEM_BYTES reaches the full 16-bit address space.
    localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);

    // Sequential PC with wrap-around at the top of instruction memory.
    function automatic logic [15:0] next_pc(input logic [15:0] cur);
        if (({1'b0, cur} + 17'd2) >= MEM_LIMIT)
            return 16'h0000;
        else
            return cur + 16'd2;
    endfunction

    // A target must be half-word aligned and inside the memory.
    function automatic logic target_legal(input logic [15:0] t);
        return (t[0] == 1'b0) && ({1'b0, t} < MEM_LIMIT);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            ir_valid <= 1'b0;
            im_read  <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    im_read  <= 1'b0;
                    ir_valid <= 1'b0;
                    // A load always takes priority over a fetch request in
                    // the same cycle; the fetch must be requested again.
                    if (pc_load) begin
                        if (target_legal(pc_target))
                            pc <= pc_target;
                        else
                            fault <= 1'b1;
                    end else if (fetch_req && !stall && !fault) begin
                        state <= ADDR;
                    end
                end
                // Address is held one full cycle with the strobe low so the
                // memory sees a clean rising edge on im_read.
                ADDR: begin
                    im_read <= 1'b1;
                    state   <= READ;
                end
                READ: begin
                    ir       <= instr_in;
                    pc       <= next_pc(pc);
                    ir_valid <= 1'b1;
                    im_read  <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    ir_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic        stall = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = 16'h0000;
    logic [15:0] instr_in;
    logic [15:0] pc;
    logic        im_read;
    logic [15:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .MEM_BYTES(32),
        .RESET_PC (16'h0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_req(fetch_req),
        .stall    (stall),
        .pc_load  (pc_load),
        .pc_target(pc_target),
        .instr_in (instr_in),
        .pc       (pc),
        .im_read  (im_read),
        .ir       (ir),
        .ir_valid (ir_valid),
        .busy     (busy),
        .fault    (fault)
    );

    // Byte-wide instruction memory model, little-endian half-word read.
    logic [7:0] mem [0:31];
    always_comb instr_in = {mem[5'(pc[4:0] + 5'd1)], mem[pc[4:0]]};

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] pc_after;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_vcyc = -1;
    bit   stream_chk = 1'b0;
    int   model_pc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expected result of one fetch from the model PC and advance it.
    task automatic push_fetch();
        exp_t e;
        int   nxt;
        nxt = (model_pc + 2 >= 32) ? 0 : model_pc + 2;
        e.word     = {mem[(model_pc + 1) % 32], mem[model_pc % 32]};
        e.pc_after = 16'(nxt);
        sb.push_back(e);
        model_pc = nxt;
    endtask

    // Scoreboard consumer: every ir_valid cycle must match a pending fetch.
    always @(negedge clk) begin
        if (!rst && ir_valid) begin : mon
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_ir_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_ir", {16'h0, ir}, {16'h0, e.word});
                check("sb_pc", {16'h0, pc}, {16'h0, e.pc_after});
            end
            if (stream_chk && last_vcyc >= 0)
                check("stream_gap", 32'(cyc - last_vcyc), 32'd4);
            last_vcyc = cyc;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fetch_req = 1'b0;
        pc_load = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_pc = 0;
        last_vcyc = -1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        check("idle_reached", {31'h0, busy}, 32'd0);
    endtask

    int busy_lows;
    int activity;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 29 + 5);
        mem[0] = 8'h06;
        mem[1] = 8'h30;

        // Reset state while rst is held
        #3;
        check("rst_pc",       {16'h0, pc},   32'h0);
        check("rst_ir",       {16'h0, ir},   32'h0);
        check("rst_ir_valid", {31'h0, ir_valid}, 32'd0);
        check("rst_im_read",  {31'h0, im_read},  32'd0);
        check("rst_busy",     {31'h0, busy},     32'd0);
        check("rst_fault",    {31'h0, fault},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_pc = 0;

        // Single fetch, cycle-accurate
        @(negedge clk);
        fetch_req = 1'b1;
        push_fetch();
        @(negedge clk);                    // after edge E: ADDR
        fetch_req = 1'b0;
        check("single_addr_busy", {31'h0, busy}, 32'd1);
        check("single_addr_rd",   {31'h0, im_read}, 32'd0);
        check("single_addr_vld",  {31'h0, ir_valid}, 32'd0);
        @(negedge clk);                    // after E+1: READ
        check("single_read_rd",   {31'h0, im_read}, 32'd1);
        check("single_read_vld",  {31'h0, ir_valid}, 32'd0);
        @(negedge clk);                    // after E+2: DONE
        check("single_done_rd",   {31'h0, im_read}, 32'd0);
        check("single_done_vld",  {31'h0, ir_valid}, 32'd1);
        check("single_ir",        {16'h0, ir}, 32'h3006);
        check("single_pc",        {16'h0, pc}, 32'h2);
        @(negedge clk);                    // after E+3: IDLE
        check("single_idle_vld",  {31'h0, ir_valid}, 32'd0);
        check("single_idle_busy", {31'h0, busy}, 32'd0);

        // Streaming: fetch_req held for 12 cycles from reset
        do_reset();
        stream_chk = 1'b1;
        fetch_req = 1'b1;
        repeat (3) push_fetch();
        busy_lows = 0;
        repeat (12) begin
            @(negedge clk);
            if (!busy) busy_lows++;
        end
        fetch_req = 1'b0;
        check("stream_busy_lows", 32'(busy_lows), 32'd3);
        wait_idle();
        repeat (2) @(negedge clk);
        stream_chk = 1'b0;
        check("stream_pc", {16'h0, pc}, 32'h6);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        // Stall holds off a fetch, release starts it
        @(negedge clk);
        stall = 1'b1;
        fetch_req = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_busy", {31'h0, busy}, 32'd0);
        check("stall_rd",   {31'h0, im_read}, 32'd0);
        push_fetch();
        stall = 1'b0;
        @(negedge clk);
        fetch_req = 1'b0;
        check("unstall_busy", {31'h0, busy}, 32'd1);
        wait_idle();

        // Wrap from the last half-word
        @(negedge clk);
        pc_load = 1'b1;
        pc_target = 16'h001E;
        @(negedge clk);
        pc_load = 1'b0;
        check("wrap_load_pc", {16'h0, pc}, 32'h1E);
        check("wrap_fault",   {31'h0, fault}, 32'd0);
        model_pc = 30;
        fetch_req = 1'b1;
        push_fetch();
        @(negedge clk);
        fetch_req = 1'b0;
        wait_idle();
        check("wrap_pc", {16'h0, pc}, 32'h0);

        // Collision: load beats fetch
        @(negedge clk);
        pc_load = 1'b1;
        pc_target = 16'h0008;
        fetch_req = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        check("coll_pc",   {16'h0, pc}, 32'h8);
        check("coll_busy", {31'h0, busy}, 32'd0);
        model_pc = 8;
        push_fetch();
        @(negedge clk);
        fetch_req = 1'b0;
        check("coll_fetch_busy", {31'h0, busy}, 32'd1);
        wait_idle();
        check("coll_pc_after", {16'h0, pc}, 32'hA);

        // Illegal targets: odd, then out of range
        @(negedge clk);
        pc_load = 1'b1;
        pc_target = 16'h0005;
        @(negedge clk);
        check("ill_odd_fault", {31'h0, fault}, 32'd1);
        check("ill_odd_pc",    {16'h0, pc}, 32'hA);
        pc_target = 16'h0020;
        @(negedge clk);
        pc_load = 1'b0;
        check("ill_range_fault", {31'h0, fault}, 32'd1);
        check("ill_range_pc",    {16'h0, pc}, 32'hA);
        fetch_req = 1'b1;
        activity = 0;
        repeat (6) begin
            @(negedge clk);
            if (im_read || ir_valid || busy) activity++;
        end
        fetch_req = 1'b0;
        check("fault_blocks_fetch", 32'(activity), 32'd0);
        pc_load = 1'b1;
        pc_target = 16'h0004;
        @(negedge clk);
        pc_load = 1'b0;
        check("fault_load_pc",    {16'h0, pc}, 32'h4);
        check("fault_stays",      {31'h0, fault}, 32'd1);
        do_reset();
        check("fault_cleared",    {31'h0, fault}, 32'd0);

        // Abort: one good fetch so ir is non-zero, then reset during READ
        @(negedge clk);
        fetch_req = 1'b1;
        push_fetch();
        @(negedge clk);
        fetch_req = 1'b0;
        wait_idle();
        check("pre_abort_ir", {16'h0, ir}, 32'h3006);
        @(negedge clk);
        fetch_req = 1'b1;                  // not pushed: must never complete
        for (int k = 0; k < 10 && !im_read; k++) @(negedge clk);
        fetch_req = 1'b0;
        check("abort_in_read", {31'h0, im_read}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_rd",   {31'h0, im_read}, 32'd0);
        check("abort_ir",   {16'h0, ir}, 32'h0);
        check("abort_vld",  {31'h0, ir_valid}, 32'd0);
        check("abort_pc",   {16'h0, pc}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_pc = 0;
        repeat (8) @(negedge clk);
        check("abort_no_ir_update", {16'h0, ir}, 32'h0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter MEM_BYTES, default 32: instruction-memory size in bytes; valid PCs are even values below MEM_BYTES.
REQ-003 Parameter RESET_PC, default 16'h0000: PC value after reset.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 fetch_req  in  1  control unit requests the next instruction; level, sampled only in IDLE.
REQ-007 stall  in  1  blocks the start of a new fetch while high.
REQ-008 pc_load  in  1  load a branch/jump target; sampled only in IDLE.
REQ-009 pc_target  in  16  branch/jump target byte address.
REQ-010 instr_in  in  16  instruction word returned by instruction memory ({byte[pc+1], byte[pc]}).
REQ-011 pc  out  16  byte address driven to instruction memory; registered.
REQ-012 im_read  out  1  read strobe to instruction memory; memory samples on its rising edge; registered.
REQ-013 ir  out  16  instruction register; registered.
REQ-014 ir_valid  out  1  one-cycle pulse: ir holds a newly fetched word.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 fault  out  1  sticky flag: illegal pc_target requested.

Function
REQ-017 FSM states SHALL be IDLE, ADDR, READ and DONE, encoded in 2 bits.
REQ-018 IDLE -> ADDR when fetch_req=1, stall=0, pc_load=0 and fault=0; otherwise stay in IDLE.
REQ-019 ADDR: im_read=0 and pc stable for one cycle, guaranteeing a fresh rising edge; transition to READ.
REQ-020 READ: im_read=1 for exactly one cycle; at the closing edge ir<=instr_in, pc<=next PC, ir_valid<=1; transition to DONE.
REQ-021 DONE: ir_valid=1 and im_read=0 for one cycle; transition to IDLE unconditionally.
REQ-022 Latency: fetch_req sampled at edge E -> im_read high during E+1..E+2 -> ir_valid high during E+2..E+3; held fetch_req gives one instruction every 4 cycles.
REQ-023 Next PC SHALL be (pc+2) modulo MEM_BYTES; pc=MEM_BYTES-2 wraps to 0.
REQ-024 pc_load in IDLE: if pc_target[0]=0 and pc_target<MEM_BYTES then pc<=pc_target, else fault<=1 and pc unchanged.
REQ-025 pc_load and fetch_req high in the same IDLE cycle: the load wins and no fetch starts; fetch_req must still be high on a later cycle to fetch.
REQ-026 pc_load, fetch_req and stall outside IDLE SHALL be ignored; an in-flight fetch always completes.
REQ-027 fault SHALL remain 1 until reset; while fault=1, no fetch starts and pc_load is still evaluated but cannot clear fault.
REQ-028 ir SHALL hold its value except at the READ->DONE edge; ir_valid is 0 in every state except DONE.
REQ-029 busy SHALL be decoded from state (1 in ADDR, READ and DONE).

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, pc=RESET_PC, ir=16'h0000, ir_valid=0, im_read=0, busy=0, fault=0.
REQ-031 Reset asserted mid-fetch (any state) SHALL abort the fetch immediately with no ir update and no ir_valid pulse.
REQ-032 After rst deasserts, the first fetch starts no earlier than the first clock edge on which the REQ-018 conditions are met.

Verification
REQ-033 Single fetch: reset, instr_in=16'h3006, fetch_req pulsed at edge E -> im_read 1 only during E+1..E+2, ir=16'h3006, ir_valid 1 only during E+2..E+3, pc 0->2.
REQ-034 Streaming: fetch_req held high for 12 cycles -> three ir_valid pulses 4 cycles apart, pc sequence 0,2,4,6, busy low one cycle between fetches.
REQ-035 Wrap: pc_load with pc_target=16'h001E, then fetch -> pc=16'h0000 after ir_valid.
REQ-036 Illegal target: pc_load with 16'h0005, then with 16'h0020 -> fault=1 after the first load, pc unchanged; a following fetch_req produces no im_read and no ir_valid.
REQ-037 Collision: pc_load=1 with target 16'h0008 and fetch_req=1 in the same IDLE cycle -> pc=16'h0008, busy stays 0; fetch_req the next cycle fetches from 8.
REQ-038 Abort: rst pulsed during READ -> im_read, ir and ir_valid go to 0 and pc to RESET_PC without waiting for a clock edge; no ir_valid pulse follows.
